alarms: RTL and testbench

ALARMS -- requirements
Module: alarms

---
 rtl/alarms_pkg.sv | 12 +
 rtl/alarms_channel.sv | 57 +++++
 rtl/alarms.sv | 33 +++
 tb/tb_alarms.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alarms_pkg.sv
// Shared constants for the alarm block.
// Channel indices map onto the raw sensor vector.
package alarms_pkg;

   localparam int FIRE_IDX    = 2;
   localparam int BURGLAR_IDX = 1;
   localparam int RAIN_IDX    = 0;
   localparam int NUM_CH      = 3;
   localparam int DEB_DEFAULT = 2;
   localparam int CNT_W       = 4;

endpackage

// File: rtl/alarms_channel.sv
// One alarm channel: 2-flop synchronizer,
// saturating debounce counter, sticky alarm latch.
module alarm_channel
   import alarms_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sens_i,
   output logic alarm_o
);

   localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEB_CYCLES);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   logic             sync1_q;
   logic             sync2_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             alarm_q;
   logic             alarm_d;

   // Count qualified samples, saturate, latch alarm at threshold.
   always_comb begin
      cnt_d   = '0;
      alarm_d = alarm_q;
      if (sync2_q) begin
         if (cnt_q >= DEB_C) begin
            cnt_d = DEB_C;
         end else begin
            cnt_d = cnt_q + ONE_C;
         end
      end
      if (cnt_d == DEB_C) begin
         alarm_d = 1'b1;
      end
   end

   // Synchronizer, counter and latch registers with async clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         alarm_q <= 1'b0;
      end else begin
         sync1_q <= sens_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         alarm_q <= alarm_d;
      end
   end

   assign alarm_o = alarm_q;

endmodule

// File: rtl/alarms.sv
// Three independent debounced, sticky alarm channels
// (fire, burglar, rain) fed from an async sensor vector.
module alarms
   import alarms_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] state,
   output logic              fire,
   output logic              burglar,
   output logic              rain
);

   logic [NUM_CH-1:0] alarm_vec;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      alarm_channel #(
         .DEB_CYCLES(DEB_CYCLES)
      ) u_ch (
         .clk    (clk),
         .rst_n  (reset),
         .sens_i (state[g]),
         .alarm_o(alarm_vec[g])
      );
   end

   assign fire    = alarm_vec[FIRE_IDX];
   assign burglar = alarm_vec[BURGLAR_IDX];
   assign rain    = alarm_vec[RAIN_IDX];

endmodule

// File: tb/tb_alarms.sv
// Directed bench for the alarm block.
// Inputs change 1 time unit after each rising edge.
module tb_alarms;

   logic       clk;
   logic       reset;
   logic [2:0] state;
   logic       fire;
   logic       burglar;
   logic       rain;

   int n_tests = 0;
   int n_fail  = 0;

   alarms #(.DEB_CYCLES(2)) dut (
      .clk    (clk),
      .reset  (reset),
      .state  (state),
      .fire   (fire),
      .burglar(burglar),
      .rain   (rain)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] outs();
      return {fire, burglar, rain};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      state = 3'b000;
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      state = 3'b000;
      reset = 1'b0;
      #2;
      n_tests++;
      if (outs() !== 3'b000) begin
         $display("FAIL reset_low: got %b want 000", outs());
         n_fail++;
      end
      tick();
      reset = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         n_tests++;
         if (outs() !== 3'b000) begin
            $display("FAIL idle_e%0d: got %b want 000", i, outs());
            n_fail++;
         end
      end
   endtask

   task automatic test_rain();
      do_reset();
      state = 3'b001;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_tests++;
         if (outs() !== ((i == 4) ? 3'b001 : 3'b000)) begin
            $display("FAIL rain_e%0d: got %b want %b", i, outs(),
                     (i == 4) ? 3'b001 : 3'b000);
            n_fail++;
         end
      end
      state = 3'b000;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_tests++;
         if (outs() !== 3'b001) begin
            $display("FAIL rain_sticky_e%0d: got %b want 001", i, outs());
            n_fail++;
         end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      state = 3'b110;
      for (int i = 1; i <= 5; i++) begin
         tick();
         n_tests++;
         if (outs() !== ((i >= 4) ? 3'b110 : 3'b000)) begin
            $display("FAIL simul_e%0d: got %b want %b", i, outs(),
                     (i >= 4) ? 3'b110 : 3'b000);
            n_fail++;
         end
      end
   endtask

   task automatic test_pulse();
      do_reset();
      state = 3'b100;
      tick();
      state = 3'b000;
      for (int i = 1; i <= 6; i++) begin
         tick();
         n_tests++;
         if (outs() !== 3'b000) begin
            $display("FAIL pulse1_e%0d: got %b want 000", i, outs());
            n_fail++;
         end
      end
      state = 3'b100;
      tick();
      tick();
      tick();
      state = 3'b000;
      n_tests++;
      if (outs() !== 3'b000) begin
         $display("FAIL pulse3_e3: got %b want 000", outs());
         n_fail++;
      end
      tick();
      n_tests++;
      if (outs() !== 3'b100) begin
         $display("FAIL pulse3_e4: got %b want 100", outs());
         n_fail++;
      end
      tick();
      tick();
      n_tests++;
      if (outs() !== 3'b100) begin
         $display("FAIL pulse3_hold: got %b want 100", outs());
         n_fail++;
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      state = 3'b010;
      for (int i = 0; i < 4; i++) tick();
      n_tests++;
      if (outs() !== 3'b010) begin
         $display("FAIL burg_latched: got %b want 010", outs());
         n_fail++;
      end
      #2;
      reset = 1'b0;
      #1;
      n_tests++;
      if (outs() !== 3'b000) begin
         $display("FAIL burg_async_clr: got %b want 000", outs());
         n_fail++;
      end
      tick();
      n_tests++;
      if (outs() !== 3'b000) begin
         $display("FAIL burg_in_reset: got %b want 000", outs());
         n_fail++;
      end
      reset = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_tests++;
         if (outs() !== ((i == 4) ? 3'b010 : 3'b000)) begin
            $display("FAIL burg_rel_e%0d: got %b want %b", i, outs(),
                     (i == 4) ? 3'b010 : 3'b000);
            n_fail++;
         end
      end
   endtask

   task automatic test_mid_qual();
      do_reset();
      state = 3'b001;
      tick();
      tick();
      tick();
      reset = 1'b0;
      #2;
      reset = 1'b1;
      tick();
      tick();
      tick();
      n_tests++;
      if (outs() !== 3'b000) begin
         $display("FAIL midqual_e3: got %b want 000", outs());
         n_fail++;
      end
      tick();
      n_tests++;
      if (outs() !== 3'b001) begin
         $display("FAIL midqual_e4: got %b want 001", outs());
         n_fail++;
      end
   endtask

   task automatic test_toggle();
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         state = (i % 2 == 1) ? 3'b001 : 3'b000;
         tick();
      end
      state = 3'b000;
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_tests++;
         if (outs() !== 3'b000) begin
            $display("FAIL toggle_e%0d: got %b want 000", i, outs());
            n_fail++;
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      state = 3'b000;
      test_reset();
      test_rain();
      test_simultaneous();
      test_pulse();
      test_reset_mid();
      test_mid_qual();
      test_toggle();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
